// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory: Funct3 encodings,
// clear-sequencer states and the load extraction/extension helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } dmem_state_e;

  function automatic logic f3_legal(input logic [2:0] funct3);
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Low address bits below the access size are ignored (forced alignment).
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      F3_W:    return word;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Store-side lane steering: byte enables, lane-replicated write data and the
// misaligned flag. Misalignment is only detected when MISALIGN_TRAP_EN is defined.
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] lane_wdata_o,
  output logic        misaligned_o
);

  logic legal;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    legal        = f3_legal(funct3_i);
    misaligned_o = 1'b0;
    byte_en_o    = '0;
    lane_wdata_o = wdata_i;
`ifdef MISALIGN_TRAP_EN
    if (legal) begin
      case (funct3_i[1:0])
        2'b01:   misaligned_o = addr_lo_i[0];
        2'b10:   misaligned_o = |addr_lo_i;
        default: misaligned_o = 1'b0;
      endcase
    end
`endif
    case (funct3_i[1:0])
      2'b00: begin
        byte_en_o    = 4'b0001 << addr_lo_i;
        lane_wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        lane_wdata_o = {2{wdata_i[15:0]}};
      end
      2'b10:   byte_en_o = 4'b1111;
      default: byte_en_o = 4'b0000;
    endcase
    if (!legal || misaligned_o) byte_en_o = '0;
  end

endmodule

// File: rtl/byte_data_memory.sv
// RV32I data memory with byte-lane stores, registered sign/zero-extended loads and
// a post-reset clear sequencer. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        Ready,
  output logic        Misaligned
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_e      state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
  logic             clr_we;
  logic [3:0][7:0]  mem_q [DEPTH];
  logic [31:0]      rdata_q;
  logic             rvalid_q;

  logic [IDX_W-1:0] word_idx;
  logic [3:0]       byte_en;
  logic [31:0]      lane_wdata;
  logic             lane_mis;
  logic             load_req, store_req;
  logic             unused_addr;

  assign word_idx    = Address[IDX_W+1:2];
  assign unused_addr = ^Address[31:IDX_W+2];
  assign Ready       = (state_q == ST_IDLE);
  assign load_req    = MemRead & Ready;
  assign store_req   = MemWrite & Ready;

  dmem_lane_ctrl u_lane_ctrl (
    .addr_lo_i    (Address[1:0]),
    .funct3_i     (Funct3),
    .wdata_i      (WriteData),
    .byte_en_o    (byte_en),
    .lane_wdata_o (lane_wdata),
    .misaligned_o (lane_mis)
  );

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // NOTE: the array has no reset branch; the clear sequencer zeroes it word by word.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      if (clr_we) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (store_req) begin
        for (int l = 0; l < 4; l++) begin
          if (byte_en[l]) mem_q[word_idx][l] <= lane_wdata[8*l +: 8];
        end
      end
    end
  end

  // Non-blocking updates give read-first behaviour when a load and store share a word.
  always_ff @(posedge Clk) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= load_req;
      if (load_req) rdata_q <= lane_mis ? '0 : load_extend(mem_q[word_idx], Address[1:0], Funct3);
    end
  end

  assign ReadData  = rdata_q;
  assign ReadValid = rvalid_q;

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  always_ff @(posedge Clk) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= lane_mis & (load_req | store_req);
  end

  assign Misaligned = mis_q;
`else
  assign Misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory: directed steps plus random traffic
// against a byte-array reference model.
module tb_byte_data_memory;

  localparam int DEPTH = 64;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        Ready;
  logic        Misaligned;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] last_rdata = '0;

  byte_data_memory #(.DEPTH(DEPTH)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Funct3     (Funct3),
    .ReadData   (ReadData),
    .ReadValid  (ReadValid),
    .Ready      (Ready),
    .Misaligned (Misaligned)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] f3);
`ifdef MISALIGN_TRAP_EN
    return legal(f3) && ((a % 4) % acc_size(f3) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int byte_base(input logic [31:0] a, input logic [2:0] f3);
    int word, off;
    word = int'((a / 4) % DEPTH);
    off  = int'(a % 4);
    off  = (off / acc_size(f3)) * acc_size(f3);
    return word * 4 + off;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int sz, base;
    if (!legal(f3) || is_mis(a, f3)) return 32'h0;
    sz   = acc_size(f3);
    base = byte_base(a, f3);
    v    = 32'h0;
    for (int k = 0; k < sz; k++) v = v + (32'(ref_mem[base + k]) << (8 * k));
    if (f3[2] == 1'b0 && sz < 4 && v >= (32'h1 << (8 * sz - 1)))
      v = v + ~((32'h1 << (8 * sz)) - 1);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int sz, base;
    if (!legal(f3) || is_mis(a, f3)) return;
    sz   = acc_size(f3);
    base = byte_base(a, f3);
    for (int k = 0; k < sz; k++) ref_mem[base + k] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  // One request cycle: drive at negedge, check at the next negedge. Consecutive
  // calls keep the request lines asserted, so loads run back to back.
  task automatic issue(input string tag, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] exp_rd;
    bit          exp_mis;
    MemRead   = rd;
    MemWrite  = wr;
    Address   = a;
    WriteData = d;
    Funct3    = f3;
    exp_rd  = rd ? model_load(a, f3) : last_rdata;
    exp_mis = is_mis(a, f3) && (rd || wr);
    if (wr) model_store(a, d, f3);
    @(posedge Clk);
    @(negedge Clk);
    check({tag, ".valid"}, 32'(ReadValid), 32'(rd));
    check({tag, ".data"}, ReadData, exp_rd);
    check({tag, ".mis"}, 32'(Misaligned), 32'(exp_mis));
    last_rdata = exp_rd;
  endtask

  task automatic idle();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("idle.valid", 32'(ReadValid), 32'h0);
  endtask

  // Requests hammer word 0 during the clear; none may be accepted.
  task automatic reset_and_clear(input string tag, input int restart_at);
    int errs;
    errs = 0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    reset    = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    check({tag, ".rst_ready"}, 32'(Ready), 32'h0);
    check({tag, ".rst_valid"}, 32'(ReadValid), 32'h0);
    check({tag, ".rst_data"}, ReadData, 32'h0);
    check({tag, ".rst_mis"}, 32'(Misaligned), 32'h0);
    for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
    last_rdata = '0;
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    Address   = 32'h0;
    WriteData = 32'hFFFF_FFFF;
    Funct3    = 3'b010;
    if (restart_at > 0) begin
      for (int i = 0; i < restart_at; i++) begin
        @(posedge Clk);
        @(negedge Clk);
        if (Ready !== 1'b0 || ReadValid !== 1'b0) errs++;
      end
      reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      reset = 1'b0;
    end
    for (int i = 1; i < DEPTH; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Ready !== 1'b0 || ReadValid !== 1'b0) errs++;
    end
    check({tag, ".busy_cycles"}, 32'(errs), 32'h0);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check({tag, ".ready_rise"}, 32'(Ready), 32'h1);
    check({tag, ".no_valid"}, 32'(ReadValid), 32'h0);
  endtask

  initial begin
    @(negedge Clk);

    reset_and_clear("por", 0);
    issue("lw_fc", 1, 0, 32'h0FC, 32'h0, 3'b010);
    check("lw_fc.zero", ReadData, 32'h0);
    issue("lw_0", 1, 0, 32'h000, 32'h0, 3'b010);
    check("lw_0.zero", ReadData, 32'h0);

    issue("sw_10", 0, 1, 32'h010, 32'hDEAD_BEEF, 3'b010);
    issue("lb_13", 1, 0, 32'h013, 32'h0, 3'b000);
    check("lb_13.lit", ReadData, 32'hFFFF_FFDE);
    issue("lbu_13", 1, 0, 32'h013, 32'h0, 3'b100);
    check("lbu_13.lit", ReadData, 32'h0000_00DE);
    issue("lh_10", 1, 0, 32'h010, 32'h0, 3'b001);
    check("lh_10.lit", ReadData, 32'hFFFF_BEEF);
    issue("lhu_12", 1, 0, 32'h012, 32'h0, 3'b101);
    check("lhu_12.lit", ReadData, 32'h0000_DEAD);
    idle();

    issue("sw_20", 0, 1, 32'h020, 32'h1122_3344, 3'b010);
    issue("sb_21", 0, 1, 32'h021, 32'h0000_0055, 3'b000);
    issue("lw_20a", 1, 0, 32'h020, 32'h0, 3'b010);
    check("lw_20a.lit", ReadData, 32'h1122_5544);
    issue("sh_22", 0, 1, 32'h022, 32'h0000_A0B0, 3'b001);
    issue("lw_20b", 1, 0, 32'h020, 32'h0, 3'b010);
    check("lw_20b.lit", ReadData, 32'hA0B0_5544);

    issue("rw_30", 1, 1, 32'h030, 32'h1234_5678, 3'b010);
    check("rw_30.old", ReadData, 32'h0);
    issue("lw_30", 1, 0, 32'h030, 32'h0, 3'b010);
    check("lw_30.new", ReadData, 32'h1234_5678);

    issue("lw_ill", 1, 0, 32'h030, 32'h0, 3'b011);
    check("lw_ill.zero", ReadData, 32'h0);
    issue("sw_ill", 0, 1, 32'h030, 32'hFFFF_FFFF, 3'b111);
    issue("lw_30c", 1, 0, 32'h030, 32'h0, 3'b010);
    check("lw_30c.keep", ReadData, 32'h1234_5678);
    idle();

    issue("sw_40", 0, 1, 32'h040, 32'hCAFE_F00D, 3'b010);
    issue("sw_41", 0, 1, 32'h041, 32'hFFFF_FFFF, 3'b010);
    issue("lw_40", 1, 0, 32'h040, 32'h0, 3'b010);
`ifdef MISALIGN_TRAP_EN
    check("lw_40.lit", ReadData, 32'hCAFE_F00D);
`else
    check("lw_40.lit", ReadData, 32'hFFFF_FFFF);
`endif
    idle();

    for (int i = 0; i < 400; i++) begin
      bit          rd, wr;
      logic [31:0] a, d;
      logic [2:0]  f3;
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      a  = $urandom;
      d  = $urandom;
      f3 = 3'($urandom_range(0, 7));
      issue($sformatf("rnd%0d", i), rd, wr, a, d, f3);
    end
    idle();

    reset_and_clear("mid", 20);
    issue("post_lw_0", 1, 0, 32'h000, 32'h0, 3'b010);
    check("post_lw_0.zero", ReadData, 32'h0);
    issue("post_lw_fc", 1, 0, 32'h0FC, 32'h0, 3'b010);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
